// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the fetch-side PC sequencer: FSM encoding,
// instruction size, default vectors and the common PC increment.
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int unsigned INSN_BYTES   = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0004;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] pc_add(input logic [31:0] pc);
    return pc + 32'(INSN_BYTES);
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Instruction-memory fetch handshake: request/address out, ack back.
interface pc_redirect_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;

  modport master (output imem_req, output imem_addr, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// Saturating event counter: counts inc cycles, sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc unless already saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: owns the PC, issues fetches over req/ack, applies
// branch-unit redirects, and drains fetches whose response went stale.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_redirect_ctrl_if.master   imem,
  input  logic                 ex_valid,
  input  logic                 take,
  input  logic [31:0]          dest,
  input  logic                 stall,
  output logic                 fetch_valid,
  output logic [31:0]          fetch_pc,
  output logic                 flush,
  output logic                 misalign,
  output logic [CNT_W-1:0]     redirect_cnt
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drain_addr;
  logic [31:0] pc_inc;
  logic [31:0] target;
  logic        redir;
  logic        mis_raw;
  logic        fv_raw;
  logic [CNT_W-1:0] cnt_q;

  assign redir   = ex_valid & take;
  assign mis_raw = redir & (dest[1:0] != 2'b00);
  assign target  = mis_raw ? TRAP_VEC : dest;
  assign pc_inc  = pc_add(pc);

  // Capture strobe: a fresh ack in FETCH, or release of the held response.
  always_comb begin
    fv_raw = 1'b0;
    unique case (state)
      ST_FETCH: fv_raw = imem.imem_ack & ~stall & ~redir;
      ST_HOLD:  fv_raw = ~stall & ~redir;
      default:  fv_raw = 1'b0;
    endcase
  end

  // Outputs are forced to their reset values while rst is high so memory
  // sees the request drop and drops its pending response.
  assign fetch_valid    = fv_raw & ~rst;
  assign flush          = redir & ~rst;
  assign misalign       = mis_raw & ~rst;
  assign imem.imem_req  = ~rst & ((state == ST_FETCH) | (state == ST_DRAIN));
  assign imem.imem_addr = rst ? RESET_PC : ((state == ST_DRAIN) ? drain_addr : pc);
  assign fetch_pc       = rst ? RESET_PC : pc;
  assign redirect_cnt   = rst ? '0 : cnt_q;

  sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redir),
    .count (cnt_q)
  );

  // PC / fetch FSM; a redirect overrides everything and ignores stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state <= ST_FETCH;
          if (redir) pc <= target;
        end
        ST_FETCH: begin
          if (redir) begin
            pc <= target;
            if (!imem.imem_ack) begin
              drain_addr <= pc;
              state      <= ST_DRAIN;
            end
          end else if (imem.imem_ack) begin
            if (stall) state <= ST_HOLD;
            else       pc    <= pc_inc;
          end
        end
        ST_HOLD: begin
          if (redir) begin
            pc    <= target;
            state <= ST_FETCH;
          end else if (!stall) begin
            pc    <= pc_inc;
            state <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (redir)         pc    <= target;
          if (imem.imem_ack) state <= ST_FETCH;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios then randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_pc_redirect_ctrl;

  localparam int          CNT_W = 6;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] TRAP  = 32'h0000_0004;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ex_valid = 1'b0;
  logic             take = 1'b0;
  logic [31:0]      dest = 32'h0;
  logic             stall = 1'b0;
  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic             flush;
  logic             misalign;
  logic [CNT_W-1:0] redirect_cnt;

  pc_redirect_ctrl_if bus();

  pc_redirect_ctrl #(.RESET_PC(RPC), .TRAP_VEC(TRAP), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (bus),
    .ex_valid     (ex_valid),
    .take         (take),
    .dest         (dest),
    .stall        (stall),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc),
    .flush        (flush),
    .misalign     (misalign),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: the PC, whether we are in the post-reset gap, whether
  // a response is parked in IF, and whether a stale fetch is still owed.
  logic [31:0] m_pc = RPC;
  logic [31:0] m_daddr = RPC;
  bit          m_gap = 1'b1;
  bit          m_hold = 1'b0;
  bit          m_drain = 1'b0;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    bit          r, mis, fetching, e_req, e_fv;
    logic [31:0] e_addr;
    r   = ex_valid & take;
    mis = r & (dest[1:0] != 2'b00);
    if (rst) begin
      chk("rst_req",   32'(bus.imem_req), 32'h0);
      chk("rst_addr",  bus.imem_addr,     RPC);
      chk("rst_fv",    32'(fetch_valid),  32'h0);
      chk("rst_fpc",   fetch_pc,          RPC);
      chk("rst_flush", 32'(flush),        32'h0);
      chk("rst_mis",   32'(misalign),     32'h0);
      chk("rst_cnt",   32'(redirect_cnt), 32'h0);
    end else begin
      fetching = !m_gap && !m_hold && !m_drain;
      e_req    = !m_gap && !m_hold;
      e_addr   = m_drain ? m_daddr : m_pc;
      e_fv     = (fetching && bus.imem_ack && !stall && !r) || (m_hold && !stall && !r);
      chk("req",   32'(bus.imem_req), 32'(e_req));
      if (e_req) chk("addr", bus.imem_addr, e_addr);
      chk("fv",    32'(fetch_valid),  32'(e_fv));
      chk("fpc",   fetch_pc,          m_pc);
      chk("flush", 32'(flush),        32'(r));
      chk("mis",   32'(misalign),     32'(mis));
      chk("cnt",   32'(redirect_cnt), 32'(m_cnt));
    end
  endtask

  task automatic model_update();
    bit          r, ack;
    logic [31:0] tgt;
    r   = ex_valid & take;
    ack = bus.imem_ack;
    tgt = (dest[1:0] != 2'b00) ? TRAP : dest;
    if (rst) begin
      m_pc = RPC; m_gap = 1; m_hold = 0; m_drain = 0; m_cnt = 0;
    end else begin
      if (r && m_cnt < CMAX) m_cnt++;
      if (m_gap) begin
        m_gap = 0;
        if (r) m_pc = tgt;
      end else if (m_hold) begin
        if (r) begin m_pc = tgt; m_hold = 0; end
        else if (!stall) begin m_pc = m_pc + 32'd4; m_hold = 0; end
      end else if (m_drain) begin
        if (r) m_pc = tgt;
        if (ack) m_drain = 0;
      end else begin
        if (r) begin
          if (!ack) begin m_daddr = m_pc; m_drain = 1; end
          m_pc = tgt;
        end else if (ack) begin
          if (stall) m_hold = 1;
          else m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic cyc(input bit a, input bit s, input bit e, input bit t, input logic [31:0] d);
    bus.imem_ack = a; stall = s; ex_valid = e; take = t; dest = d;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) cyc(1, 0, 0, 0, 32'h0);
    rst = 1'b0;

    // 1: ack tied high after reset, back-to-back fetches
    chk("t1_req_gap", 32'(bus.imem_req), 32'h0);
    chk("t1_fpc_rst", fetch_pc, 32'h0);
    cyc(1, 0, 0, 0, 32'h0);
    chk("t1_req_up", 32'(bus.imem_req), 32'h1);
    chk("t1_fpc0", fetch_pc, 32'h0);
    cyc(1, 0, 0, 0, 32'h0);
    chk("t1_fpc4", fetch_pc, 32'h4);
    cyc(1, 0, 0, 0, 32'h0);
    chk("t1_fpc8", fetch_pc, 32'h8);

    // 2: stall on ack parks the response, release delivers it once
    repeat (3) cyc(1, 1, 0, 0, 32'h0);
    chk("t2_hold_req", 32'(bus.imem_req), 32'h0);
    stall = 1'b0; #1;
    chk("t2_rel_fv",  32'(fetch_valid), 32'h1);
    chk("t2_rel_fpc", fetch_pc, 32'h8);
    cyc(1, 0, 0, 0, 32'h0);
    chk("t2_next_fpc", fetch_pc, 32'hC);

    // 3: redirect while a request is pending, ack arrives two cycles later
    cyc(0, 0, 1, 1, 32'h100);
    chk("t3_drain_addr", bus.imem_addr, 32'hC);
    cyc(0, 0, 0, 0, 32'h0);
    chk("t3_drain_addr2", bus.imem_addr, 32'hC);
    cyc(1, 0, 0, 0, 32'h0);
    chk("t3_new_addr", bus.imem_addr, 32'h100);

    // 4: misaligned target goes to the trap vector
    cyc(1, 0, 1, 1, 32'h102);
    chk("t4_trap_addr", bus.imem_addr, TRAP);
    chk("t4_cnt", 32'(redirect_cnt), 32'h2);

    // 5: two redirects inside one drain, last wins; then PC wrap
    cyc(0, 0, 1, 1, 32'h200);
    cyc(0, 0, 1, 1, 32'h300);
    cyc(1, 0, 0, 0, 32'h0);
    chk("t5_last_wins", bus.imem_addr, 32'h300);
    chk("t5_cnt", 32'(redirect_cnt), 32'h4);
    cyc(1, 0, 1, 1, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 32'h0);
    chk("t5_wrap", fetch_pc, 32'h0);

    // 6: reset mid-FETCH and mid-DRAIN
    rst = 1'b1;
    cyc(0, 0, 0, 0, 32'h0);
    rst = 1'b0;
    chk("t6f_req", 32'(bus.imem_req), 32'h0);
    chk("t6f_cnt", 32'(redirect_cnt), 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    cyc(0, 0, 1, 1, 32'h40);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 32'h0);
    rst = 1'b0;
    chk("t6d_req", 32'(bus.imem_req), 32'h0);
    chk("t6d_fpc", fetch_pc, RPC);

    // Counter saturation under continuous redirects
    repeat (CMAX + 6) cyc(1'($urandom_range(1)), 0, 1, 1, {$urandom, 2'b00} >> 2 << 2);
    chk("sat_max", 32'(redirect_cnt), 32'(CMAX));
    cyc(1, 0, 1, 1, 32'h80);
    chk("sat_hold", 32'(redirect_cnt), 32'(CMAX));

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic [31:0] d;
      rst = ($urandom_range(59) == 0);
      d   = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      cyc(1'($urandom_range(1)), ($urandom_range(2) == 0),
          1'($urandom_range(1)), ($urandom_range(3) == 0), d);
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
